// File: rtl/sobel_window.sv
// sobel_window: streaming 3x3 neighbourhood generator.
// Two line buffers hold the previous two image lines; a registered 3x3
// window slides one column per accepted pixel and carries framing flags
// so the downstream gradient kernel can consume one window per pixel.
module sobel_window #(
  parameter int IMG_WIDTH = 32,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  data_valid,
  input  logic                  h_sync,
  input  logic                  v_sync,
  output logic [9*DATA_W-1:0]   win_data,
  output logic                  win_valid,
  output logic                  win_hsync,
  output logic                  win_vsync
);

  localparam int ADDR_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] ROW_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  // Frame lock and position counters
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] colCnt_q, colCnt_d;
  logic [CNT_W-1:0] rowCnt_q, rowCnt_d;
  logic             accept;

  // Line buffers: lbTop holds the line two above, lbMid the line directly above
  logic [DATA_W-1:0] lbTop [IMG_WIDTH];
  logic [DATA_W-1:0] lbMid [IMG_WIDTH];
  logic [ADDR_W-1:0] lbAddr;
  logic [DATA_W-1:0] topPix;
  logic [DATA_W-1:0] midPix;

  // Window registers, indexed [row][col]; row 0 is the oldest line, col 0 the oldest column
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] win_d [3][3];

  // Framing flags
  logic inWindow;
  logic winValid_q, winValid_d;
  logic winHsync_q, winHsync_d;
  logic winVsync_q, winVsync_d;

  // A pixel counts only once a frame start has been seen; a v_sync pixel is always taken
  always_comb begin
    accept = data_valid && (locked_q || v_sync);
  end

  // Compute the column/row of the incoming pixel, handling explicit and implicit line ends
  always_comb begin
    locked_d = locked_q;
    colCnt_d = colCnt_q;
    rowCnt_d = rowCnt_q;
    if (accept) begin
      locked_d = 1'b1;
      if (v_sync) begin
        colCnt_d = '0;
        rowCnt_d = '0;
      end else if (h_sync || (colCnt_q == LAST_COL)) begin
        colCnt_d = '0;
        rowCnt_d = (rowCnt_q == ROW_MAX) ? rowCnt_q : rowCnt_q + CNT_ONE;
      end else begin
        colCnt_d = colCnt_q + CNT_ONE;
      end
    end
  end

  // Line buffers are addressed by the column of the pixel being accepted
  always_comb begin
    lbAddr = colCnt_d[ADDR_W-1:0];
    topPix = lbTop[lbAddr];
    midPix = lbMid[lbAddr];
  end

  // Shift the column history down one line; reads above see the pre-write contents
  always_ff @(posedge clk) begin
    if (accept) begin
      lbTop[lbAddr] <= midPix;
      lbMid[lbAddr] <= data_in;
    end
  end

  // Slide the window left by one column and append the new vertical column on the right
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = topPix;
      win_d[1][2] = midPix;
      win_d[2][2] = data_in;
    end
  end

  // A window is complete once two full lines and two columns sit behind the new pixel
  always_comb begin
    inWindow   = accept && (rowCnt_d >= CNT_TWO) && (colCnt_d >= CNT_TWO);
    winValid_d = inWindow;
    winHsync_d = inWindow && (colCnt_d == CNT_TWO);
    winVsync_d = winHsync_d && (rowCnt_d == CNT_TWO);
  end

  // Register lock, counters, window and flags; reset clears everything except the line buffers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked_q   <= 1'b0;
      colCnt_q   <= '0;
      rowCnt_q   <= '0;
      winValid_q <= 1'b0;
      winHsync_q <= 1'b0;
      winVsync_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      locked_q   <= locked_d;
      colCnt_q   <= colCnt_d;
      rowCnt_q   <= rowCnt_d;
      winValid_q <= winValid_d;
      winHsync_q <= winHsync_d;
      winVsync_q <= winVsync_d;
      win_q      <= win_d;
    end
  end

  // Flatten the window so pixel 3*r+c lands at bits [(3*r+c)*DATA_W +: DATA_W]
  for (genvar gr = 0; gr < 3; gr++) begin : g_row
    for (genvar gc = 0; gc < 3; gc++) begin : g_col
      assign win_data[(3*gr+gc)*DATA_W +: DATA_W] = win_q[gr][gc];
    end
  end

  assign win_valid = winValid_q;
  assign win_hsync = winHsync_q;
  assign win_vsync = winVsync_q;

endmodule

// File: tb/tb_sobel_window.sv
// tb_sobel_window: scenario-driven bench for sobel_window with a
// column-history reference model of the line buffers and window.
module tb_sobel_window;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  data_in = '0;
  logic        data_valid = 1'b0;
  logic        h_sync = 1'b0;
  logic        v_sync = 1'b0;
  logic [71:0] win_data;
  logic        win_valid;
  logic        win_hsync;
  logic        win_vsync;

  sobel_window #(.IMG_WIDTH(W), .DATA_W(8), .CNT_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .win_data   (win_data),
    .win_valid  (win_valid),
    .win_hsync  (win_hsync),
    .win_vsync  (win_vsync)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] top;
    logic [7:0] mid;
    logic [7:0] bot;
    logic       known;
  } colRec_t;

  int          errors = 0;
  int          checks = 0;

  bit          mLocked;
  int          mRow;
  int          mCol;
  logic [7:0]  histLast [W];
  logic [7:0]  histPrev [W];
  int          histCnt  [W];
  colRec_t     recent[$];
  logic [71:0] expData;
  logic        expValid;
  logic        expH;
  logic        expV;
  logic        expKnown;
  logic [71:0] rampWins[$];

  function automatic logic [7:0] rampPix(input int r, input int c);
    return 8'((r * W + c) & 255);
  endfunction

  function automatic void buildWindow();
    expKnown = 1'b1;
    for (int c = 0; c < 3; c++) begin
      expData[(0*3+c)*8 +: 8] = recent[c].top;
      expData[(1*3+c)*8 +: 8] = recent[c].mid;
      expData[(2*3+c)*8 +: 8] = recent[c].bot;
      if (!recent[c].known) expKnown = 1'b0;
    end
  endfunction

  function automatic void modelReset();
    colRec_t z;
    z = '{top: 8'h00, mid: 8'h00, bot: 8'h00, known: 1'b1};
    mLocked = 1'b0;
    mRow = 0;
    mCol = 0;
    recent.delete();
    for (int i = 0; i < 3; i++) recent.push_back(z);
    expValid = 1'b0;
    expH = 1'b0;
    expV = 1'b0;
    buildWindow();
  endfunction

  // Drive one cycle of input and advance the reference model; returns #1 after the edge
  task automatic stepPixel(input logic [7:0] d, input logic dv, input logic hs, input logic vs);
    colRec_t rec;
    logic    acc;
    @(negedge clk);
    data_in = d;
    data_valid = dv;
    h_sync = hs;
    v_sync = vs;
    acc = dv && (mLocked || vs);
    expValid = 1'b0;
    expH = 1'b0;
    expV = 1'b0;
    if (acc) begin
      mLocked = 1'b1;
      if (vs) begin
        mRow = 0;
        mCol = 0;
      end else if (hs || mCol == W - 1) begin
        mCol = 0;
        if (mRow < 1023) mRow++;
      end else begin
        mCol++;
      end
      rec.bot = d;
      rec.mid = (histCnt[mCol] >= 1) ? histLast[mCol] : 8'h00;
      rec.top = (histCnt[mCol] >= 2) ? histPrev[mCol] : 8'h00;
      rec.known = (histCnt[mCol] >= 2);
      histPrev[mCol] = histLast[mCol];
      histLast[mCol] = d;
      histCnt[mCol]++;
      recent.push_back(rec);
      void'(recent.pop_front());
      expValid = (mRow >= 2) && (mCol >= 2);
      expH = expValid && (mCol == 2);
      expV = expH && (mRow == 2);
      buildWindow();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    modelReset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      data_in = 8'($urandom);
      data_valid = 1'($urandom);
      h_sync = 1'($urandom);
      v_sync = 1'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if ({win_data, win_valid, win_hsync, win_vsync} !== 75'd0) begin
        errors++;
        $display("[TB] FAIL reset_hold: got data=%h v/h/vs=%b%b%b, want all zero", win_data, win_valid, win_hsync, win_vsync);
      end
    end
    @(negedge clk);
    data_valid = 1'b0;
    v_sync = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      stepPixel(8'($urandom), 1'b1, 1'($urandom), 1'b0);
      checks++;
      if (win_valid !== 1'b0 || win_data !== 72'd0) begin
        errors++;
        $display("[TB] FAIL pre_vsync_idle: got valid=%b data=%h, want valid=0 data=0", win_valid, win_data);
      end
    end
  endtask

  task automatic test_full_rate_ramp();
    int rowWin [W];
    int total;
    int badRows;
    bit seenFirst;
    total = 0;
    seenFirst = 0;
    for (int r = 0; r < W; r++) rowWin[r] = 0;
    rampWins.delete();
    for (int r = 0; r < W; r++) begin
      for (int c = 0; c < W; c++) begin
        stepPixel(rampPix(r, c), 1'b1, c == 0, r == 0 && c == 0);
        if (expValid) rampWins.push_back(expData);
        checks++;
        if ({win_valid, win_hsync, win_vsync} !== {expValid, expH, expV}) begin
          errors++;
          $display("[TB] FAIL ramp_flags (%0d,%0d): got %b%b%b, want %b%b%b", r, c, win_valid, win_hsync, win_vsync, expValid, expH, expV);
        end
        if (expKnown) begin
          checks++;
          if (win_data !== expData) begin
            errors++;
            $display("[TB] FAIL ramp_data (%0d,%0d): got %h, want %h", r, c, win_data, expData);
          end
        end
        if (win_valid === 1'b1) begin
          rowWin[r]++;
          total++;
        end
        if (win_valid === 1'b1 && !seenFirst) begin
          seenFirst = 1;
          checks++;
          if (r != 2 || c != 2 || win_hsync !== 1'b1 || win_vsync !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ramp_first_window: got at (%0d,%0d) h=%b v=%b, want at (2,2) h=1 v=1", r, c, win_hsync, win_vsync);
          end
          checks++;
          if (win_data[0 +: 8] !== 8'h00 || win_data[32 +: 8] !== 8'h21 || win_data[64 +: 8] !== 8'h42) begin
            errors++;
            $display("[TB] FAIL ramp_first_pixels: got w00=%h w11=%h w22=%h, want 00 21 42", win_data[0 +: 8], win_data[32 +: 8], win_data[64 +: 8]);
          end
        end
      end
    end
    badRows = 0;
    for (int r = 0; r < W; r++) begin
      if (rowWin[r] != ((r >= 2) ? 30 : 0)) badRows++;
    end
    checks++;
    if (total != 900) begin
      errors++;
      $display("[TB] FAIL ramp_total: got %0d windows, want 900", total);
    end
    checks++;
    if (badRows != 0) begin
      errors++;
      $display("[TB] FAIL ramp_per_row: got %0d rows with wrong count, want 0 (30 per row)", badRows);
    end
  endtask

  task automatic test_input_gaps();
    int idx;
    int gaps;
    idx = 0;
    for (int r = 0; r < W; r++) begin
      for (int c = 0; c < W; c++) begin
        gaps = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        for (int g = 0; g < gaps; g++) begin
          stepPixel(8'($urandom), 1'b0, 1'($urandom), 1'($urandom));
          checks++;
          if (win_valid !== 1'b0 || win_data !== expData) begin
            errors++;
            $display("[TB] FAIL gap_hold (%0d,%0d): got valid=%b data=%h, want valid=0 data=%h", r, c, win_valid, win_data, expData);
          end
        end
        stepPixel(rampPix(r, c), 1'b1, c == 0, r == 0 && c == 0);
        checks++;
        if ({win_valid, win_hsync, win_vsync} !== {expValid, expH, expV}) begin
          errors++;
          $display("[TB] FAIL gap_flags (%0d,%0d): got %b%b%b, want %b%b%b", r, c, win_valid, win_hsync, win_vsync, expValid, expH, expV);
        end
        if (win_valid === 1'b1) begin
          checks++;
          if (idx >= rampWins.size() || win_data !== rampWins[idx]) begin
            errors++;
            $display("[TB] FAIL gap_sequence #%0d: got %h, want ramp window", idx, win_data);
          end
          idx++;
        end
      end
    end
    checks++;
    if (idx != 900) begin
      errors++;
      $display("[TB] FAIL gap_total: got %0d windows, want 900", idx);
    end
  endtask

  task automatic test_presync_discard();
    int idx;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      stepPixel(8'($urandom), 1'b1, 1'($urandom), 1'b0);
      checks++;
      if (win_valid !== 1'b0 || win_data !== 72'd0) begin
        errors++;
        $display("[TB] FAIL presync_output: got valid=%b data=%h, want valid=0 data=0", win_valid, win_data);
      end
    end
    idx = 0;
    for (int r = 0; r < W; r++) begin
      for (int c = 0; c < W; c++) begin
        stepPixel(rampPix(r, c), 1'b1, c == 0, r == 0 && c == 0);
        checks++;
        if ({win_valid, win_hsync, win_vsync} !== {expValid, expH, expV}) begin
          errors++;
          $display("[TB] FAIL presync_flags (%0d,%0d): got %b%b%b, want %b%b%b", r, c, win_valid, win_hsync, win_vsync, expValid, expH, expV);
        end
        if (win_valid === 1'b1) begin
          checks++;
          if (idx >= rampWins.size() || win_data !== rampWins[idx]) begin
            errors++;
            $display("[TB] FAIL presync_sequence #%0d: got %h, want ramp window", idx, win_data);
          end
          idx++;
        end
      end
    end
    checks++;
    if (idx != 900) begin
      errors++;
      $display("[TB] FAIL presync_total: got %0d windows, want 900", idx);
    end
  endtask

  task automatic test_mid_frame_reset();
    int idx;
    for (int k = 0; k < W * W; k++) begin
      if (k == 10 * W + 5) begin
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        #1;
        checks++;
        if ({win_data, win_valid, win_hsync, win_vsync} !== 75'd0) begin
          errors++;
          $display("[TB] FAIL midreset_async: got data=%h v/h/vs=%b%b%b, want all zero", win_data, win_valid, win_hsync, win_vsync);
        end
        @(negedge clk);
        data_valid = 1'b0;
        v_sync = 1'b0;
        rst = 1'b1;
      end
      stepPixel(rampPix(k / W, k % W), 1'b1, (k % W) == 0, k == 0);
      checks++;
      if ({win_valid, win_hsync, win_vsync} !== {expValid, expH, expV}) begin
        errors++;
        $display("[TB] FAIL midreset_flags k=%0d: got %b%b%b, want %b%b%b", k, win_valid, win_hsync, win_vsync, expValid, expH, expV);
      end
    end
    idx = 0;
    for (int r = 0; r < W; r++) begin
      for (int c = 0; c < W; c++) begin
        stepPixel(rampPix(r, c), 1'b1, c == 0, r == 0 && c == 0);
        if (win_valid === 1'b1) begin
          checks++;
          if (idx >= rampWins.size() || win_data !== rampWins[idx]) begin
            errors++;
            $display("[TB] FAIL midreset_sequence #%0d: got %h, want ramp window", idx, win_data);
          end
          idx++;
        end
      end
    end
    checks++;
    if (idx != 900) begin
      errors++;
      $display("[TB] FAIL midreset_total: got %0d windows, want 900", idx);
    end
  endtask

  task automatic test_early_line_end();
    int   hsK;
    int   vsK;
    logic vsFlag;
    logic hs;
    hsK = -1;
    vsK = -1;
    vsFlag = 1'b0;
    for (int k = 0; k < 380; k++) begin
      if (k < 212)      hs = (k % W) == 0;
      else if (k < 252) hs = ((k - 212) % W) == 0;
      else              hs = ((k - 252) % W) == 0;
      stepPixel(8'($urandom), 1'b1, hs, k == 0 || k == 252);
      checks++;
      if ({win_valid, win_hsync, win_vsync} !== {expValid, expH, expV}) begin
        errors++;
        $display("[TB] FAIL early_flags k=%0d: got %b%b%b, want %b%b%b", k, win_valid, win_hsync, win_vsync, expValid, expH, expV);
      end
      if (expKnown) begin
        checks++;
        if (win_data !== expData) begin
          errors++;
          $display("[TB] FAIL early_data k=%0d: got %h, want %h", k, win_data, expData);
        end
      end
      if (k > 212 && hsK < 0 && win_hsync === 1'b1) hsK = k;
      if (k >= 252 && vsK < 0 && win_valid === 1'b1) begin
        vsK = k;
        vsFlag = win_vsync;
      end
    end
    checks++;
    if (hsK != 214) begin
      errors++;
      $display("[TB] FAIL early_hsync_pos: got first hsync at step %0d, want 214", hsK);
    end
    checks++;
    if (vsK != 318 || vsFlag !== 1'b1) begin
      errors++;
      $display("[TB] FAIL resync_first_window: got step %0d vsync=%b, want step 318 vsync=1", vsK, vsFlag);
    end
  endtask

  // Run every scenario in order and report the totals
  initial begin
    for (int i = 0; i < W; i++) begin
      histCnt[i] = 0;
      histLast[i] = 8'h00;
      histPrev[i] = 8'h00;
    end
    test_reset();
    test_full_rate_ramp();
    test_input_gaps();
    test_presync_discard();
    test_mid_frame_reset();
    test_early_line_end();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
